// File: rtl/snn_reward_learner_pkg.sv
// Shared types, reward encodings, FSM states and saturating arithmetic
// for the reward-modulated learning stage.
package snn_pkg;

    localparam int W_WIDTH_DEF     = 5;
    localparam int TRACE_WIDTH_DEF = 4;

    typedef logic signed [W_WIDTH_DEF-1:0]     weight_t;
    typedef logic signed [TRACE_WIDTH_DEF-1:0] trace_t;

    localparam logic [1:0] REWARD_POS  = 2'b01;
    localparam logic [1:0] REWARD_ZERO = 2'b00;
    localparam logic [1:0] REWARD_NEG  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WAIT_REWARD,
        S_APPLY
    } state_t;

    // Clamp a + b into the signed range of the given bit width.
    function automatic int sat_add(input int a, input int b, input int width);
        int sum;
        int max_v;
        int min_v;
        sum   = a + b;
        max_v = (1 << (width - 1)) - 1;
        min_v = -(1 << (width - 1));
        if (sum > max_v) return max_v;
        if (sum < min_v) return min_v;
        return sum;
    endfunction

    // The unused 2'b10 encoding is deliberately folded into -1.
    function automatic int reward_sign(input logic [1:0] r);
        if (r == REWARD_POS)  return 1;
        if (r == REWARD_ZERO) return 0;
        return -1;
    endfunction

endpackage

// File: rtl/snn_reward_learner_if.sv
// Step/reward handshakes and learned-weight outputs of the learning stage.
interface snn_reward_learner_if #(
    parameter int W_WIDTH = 5
);
    logic                      step_valid;
    logic                      step_ready;
    logic                      pre_a;
    logic                      pre_b;
    logic                      post_1;
    logic                      post_2;
    logic                      reward_valid;
    logic [1:0]                reward;
    logic                      reward_ready;
    logic signed [W_WIDTH-1:0] weight1;
    logic signed [W_WIDTH-1:0] weight2;
    logic signed [W_WIDTH-1:0] weight3;
    logic signed [W_WIDTH-1:0] weight4;
    logic                      episode_done;

    modport master (
        output step_valid, pre_a, pre_b, post_1, post_2, reward_valid, reward,
        input  step_ready, reward_ready, weight1, weight2, weight3, weight4, episode_done
    );

    modport slave (
        input  step_valid, pre_a, pre_b, post_1, post_2, reward_valid, reward,
        output step_ready, reward_ready, weight1, weight2, weight3, weight4, episode_done
    );
endinterface

// File: rtl/snn_reward_learner_sat_counter.sv
// Signed saturating counter: clear has priority, then up, then down, else hold.
module snn_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    up,
    input  logic                    down,
    output logic signed [WIDTH-1:0] value
);
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [WIDTH-1:0] value_q;
    logic signed [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (up && (value_q != MAX_V)) begin
            value_d = value_q + ONE_V;
        end else if (down && (value_q != MIN_V)) begin
            value_d = value_q - ONE_V;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/snn_reward_learner.sv
// Reward-modulated learner: collects per-synapse eligibility over an episode,
// then nudges four persistent signed weights by reward x sign(trace).
module snn_reward_learner
    import snn_pkg::*;
#(
    parameter int W_WIDTH     = W_WIDTH_DEF,
    parameter int TRACE_WIDTH = TRACE_WIDTH_DEF,
    parameter int WINDOW      = 8,
    parameter int INIT_W      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    snn_reward_learner_if.slave  bus
);
    localparam int CNT_W = $clog2(WINDOW + 1) + 1;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d, count_inc;
    logic [1:0]                 reward_q, reward_d;
    logic signed [W_WIDTH-1:0]  weight_q [4];
    logic signed [W_WIDTH-1:0]  weight_d [4];
    logic                       episode_done_q, episode_done_d;
    logic signed [TRACE_WIDTH-1:0] trace [4];

    logic       step_ready_int;
    logic       reward_ready_int;
    logic       step_fire;
    logic       reward_fire;
    logic       trace_clr;
    logic [3:0] pre_vec, post_vec, trace_up, trace_down;

    assign step_ready_int   = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign reward_ready_int = (state_q == S_WAIT_REWARD);
    assign step_fire        = bus.step_valid && step_ready_int;
    assign reward_fire      = bus.reward_valid && reward_ready_int;
    assign count_inc        = count_q + CNT_W'(1);

    // Synapse index order: 0=A->1, 1=A->2, 2=B->1, 3=B->2.
    assign pre_vec    = {bus.pre_b, bus.pre_b, bus.pre_a, bus.pre_a};
    assign post_vec   = {bus.post_2, bus.post_1, bus.post_2, bus.post_1};
    assign trace_up   = {4{step_fire}} & pre_vec & post_vec;
    assign trace_down = {4{step_fire}} & pre_vec & ~post_vec;

    for (genvar i = 0; i < 4; i++) begin : g_trace
        snn_sat_counter #(.WIDTH(TRACE_WIDTH)) u_trace (
            .clk   (clk),
            .rst   (rst),
            .clr   (trace_clr),
            .up    (trace_up[i]),
            .down  (trace_down[i]),
            .value (trace[i])
        );
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        reward_d       = reward_q;
        weight_d       = weight_q;
        episode_done_d = 1'b0;
        trace_clr      = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (step_fire) begin
                    count_d = count_inc;
                    state_d = (count_inc == CNT_W'(WINDOW)) ? S_WAIT_REWARD : S_COLLECT;
                end
            end
            S_WAIT_REWARD: begin
                if (reward_fire) begin
                    reward_d = bus.reward;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                for (int i = 0; i < 4; i++) begin
                    weight_d[i] = W_WIDTH'(sat_add(int'(weight_q[i]),
                        reward_sign(reward_q) *
                        ((trace[i] > 0) ? 1 : ((trace[i] < 0) ? -1 : 0)),
                        W_WIDTH));
                end
                count_d        = '0;
                trace_clr      = 1'b1;
                episode_done_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            reward_q       <= REWARD_ZERO;
            episode_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) weight_q[i] <= W_WIDTH'(INIT_W);
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            reward_q       <= reward_d;
            episode_done_q <= episode_done_d;
            weight_q       <= weight_d;
        end
    end

    assign bus.step_ready   = step_ready_int;
    assign bus.reward_ready = reward_ready_int;
    assign bus.weight1      = weight_q[0];
    assign bus.weight2      = weight_q[1];
    assign bus.weight3      = weight_q[2];
    assign bus.weight4      = weight_q[3];
    assign bus.episode_done = episode_done_q;
endmodule
